// File: rtl/vga_scan_timing_if.sv
// Pixel-side bundle between the VGA scan generator and its compositor and pin consumers.
// The master drives the coordinates, strobes and registered pins; the slave returns the colour.
interface vga_scan_timing_if;
  logic [11:0] color;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        active;
  logic        pix_en;
  logic        frame_start;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;
  logic        hs;
  logic        vs;

  modport master (
    input  color,
    output x, y, active, pix_en, frame_start, r, g, b, hs, vs
  );

  modport slave (
    output color,
    input  x, y, active, pix_en, frame_start, r, g, b, hs, vs
  );
endinterface

// File: rtl/vga_scan_timing.sv
// Raster scan generator and registered RGB/sync output stage for a 640x480@60 display path.
// The pixel rate comes from a clock enable on the system clock; there is one clock domain.
module vga_scan_timing #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  vga_scan_timing_if.master  vga
);

  localparam int unsigned HTot = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTot = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [9:0]      HLast   = 10'(HTot - 1);
  localparam logic [9:0]      VLast   = 10'(VTot - 1);
  localparam logic [9:0]      HVis    = 10'(H_VIS);
  localparam logic [9:0]      VVis    = 10'(V_VIS);
  localparam logic [9:0]      HsStart = 10'(H_VIS + H_FP);
  localparam logic [9:0]      HsEnd   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0]      VsStart = 10'(V_VIS + V_FP);
  localparam logic [9:0]      VsEnd   = 10'(V_VIS + V_FP + V_SYNC);

  logic [DivW-1:0] r_div_cnt;
  logic [9:0]      r_h_cnt;
  logic [9:0]      r_v_cnt;
  logic            r_frame_start;
  logic [11:0]     r_rgb;
  logic            r_hs;
  logic            r_vs;

  logic w_pix_en;
  logic w_h_last;
  logic w_v_last;
  logic w_active;
  logic w_hs_raw;
  logic w_vs_raw;

  assign w_pix_en = (r_div_cnt == DivLast);
  assign w_h_last = (r_h_cnt == HLast);
  assign w_v_last = (r_v_cnt == VLast);
  assign w_active = (r_h_cnt < HVis) && (r_v_cnt < VVis);
  assign w_hs_raw = (r_h_cnt >= HsStart) && (r_h_cnt < HsEnd);
  assign w_vs_raw = (r_v_cnt >= VsStart) && (r_v_cnt < VsEnd);

  // Decoded straight from the counters so the compositor sees a stable x/y for a whole pixel.
  assign vga.x           = w_active ? r_h_cnt : '0;
  assign vga.y           = w_active ? r_v_cnt[8:0] : '0;
  assign vga.active      = w_active;
  assign vga.pix_en      = w_pix_en;
  assign vga.frame_start = r_frame_start;
  assign vga.r           = r_rgb[11:8];
  assign vga.g           = r_rgb[7:4];
  assign vga.b           = r_rgb[3:0];
  assign vga.hs          = r_hs;
  assign vga.vs          = r_vs;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt     <= '0;
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_frame_start <= 1'b0;
      r_rgb         <= 12'h000;
      r_hs          <= ~SYNC_POL;
      r_vs          <= ~SYNC_POL;
    end else begin
      r_div_cnt     <= w_pix_en ? '0 : r_div_cnt + DivW'(1);
      r_frame_start <= w_pix_en && w_h_last && w_v_last;
      if (w_pix_en) begin
        r_h_cnt <= w_h_last ? '0 : r_h_cnt + 10'd1;
        if (w_h_last) begin
          r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
        end
        // Pins are captured from the pre-advance counters: one pixel of latency, all aligned.
        r_rgb <= w_active ? vga.color : 12'h000;
        r_hs  <= w_hs_raw ? SYNC_POL : ~SYNC_POL;
        r_vs  <= w_vs_raw ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing on a shrunken raster so whole frames fit in a short run.
// Hand-computed vectors, multi-cycle sync/frame measurements and a random run against a model.
module tb_vga_scan_timing;

  localparam int D      = 3;
  localparam int HV     = 8;
  localparam int HF     = 2;
  localparam int HS     = 3;
  localparam int HB     = 2;
  localparam int VV     = 5;
  localparam int VF     = 1;
  localparam int VS     = 2;
  localparam int VB     = 1;
  localparam int HT     = HV + HF + HS + HB;
  localparam int VT     = VV + VF + VS + VB;
  localparam int FRAME  = HT * VT * D;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  vga_scan_timing_if vga ();

  vga_scan_timing #(
    .CLK_DIV  (D),
    .H_VIS    (HV),
    .H_FP     (HF),
    .H_SYNC   (HS),
    .H_BP     (HB),
    .V_VIS    (VV),
    .V_FP     (VF),
    .V_SYNC   (VS),
    .V_BP     (VB),
    .SYNC_POL (1'b0)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .vga (vga)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: clocks since reset release, plus the pin values it implies.
  int          m_n;
  logic [11:0] m_rgb;
  logic        m_hs;
  logic        m_vs;

  typedef struct {
    int          adv;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        act;
    logic        pe;
    logic        fs;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [35:0] dut_vec();
    return {vga.x, vga.y, vga.active, vga.pix_en, vga.frame_start,
            vga.r, vga.g, vga.b, vga.hs, vga.vs};
  endfunction

  function automatic logic [35:0] model_vec();
    int   p;
    int   h;
    int   v;
    logic act;
    logic pe;
    logic fs;
    logic [9:0] xv;
    logic [8:0] yv;
    p   = m_n / D;
    h   = p % HT;
    v   = (p / HT) % VT;
    act = (h < HV) && (v < VV);
    xv  = act ? 10'(h) : 10'd0;
    yv  = act ? 9'(v) : 9'd0;
    pe  = (m_n % D) == (D - 1);
    fs  = (m_n > 0) && (m_n % FRAME == 0);
    return {xv, yv, act, pe, fs, m_rgb, m_hs, m_vs};
  endfunction

  task automatic chk(input string name, input logic [35:0] got, input logic [35:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock: present inputs, take the edge, advance the model, settle past the edge.
  task automatic step(input logic rst_v, input logic [11:0] col_v);
    int p;
    int h;
    int v;
    rst       = rst_v;
    vga.color = col_v;
    @(posedge clk);
    if (rst_v) begin
      m_n   = 0;
      m_rgb = 12'h000;
      m_hs  = 1'b1;
      m_vs  = 1'b1;
    end else begin
      if (m_n % D == D - 1) begin
        p     = m_n / D;
        h     = p % HT;
        v     = (p / HT) % VT;
        m_rgb = ((h < HV) && (v < VV)) ? col_v : 12'h000;
        m_hs  = !((h >= HV + HF) && (h < HV + HF + HS));
        m_vs  = !((v >= VV + VF) && (v < VV + VF + VS));
      end
      m_n++;
    end
    #1;
  endtask

  initial begin
    int   hs_fall1;
    int   hs_rise1;
    int   hs_fall2;
    int   vs_fall;
    int   vs_rise;
    int   fs1;
    int   fs2;
    logic prev_hs;
    logic prev_vs;

    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    vga.color = 12'h000;
    m_n       = 0;
    m_rgb     = 12'h000;
    m_hs      = 1'b1;
    m_vs      = 1'b1;

    tbl[0]  = '{0,   10'd0, 9'd0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1};
    tbl[1]  = '{2,   10'd0, 9'd0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1};
    tbl[2]  = '{1,   10'd1, 9'd0, 1'b1, 1'b0, 1'b0, 12'hF0A, 1'b1, 1'b1};
    tbl[3]  = '{21,  10'd0, 9'd0, 1'b0, 1'b0, 1'b0, 12'hF0A, 1'b1, 1'b1};
    tbl[4]  = '{3,   10'd0, 9'd0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1};
    tbl[5]  = '{6,   10'd0, 9'd0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1};
    tbl[6]  = '{9,   10'd0, 9'd0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1};
    tbl[7]  = '{3,   10'd0, 9'd1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1};
    tbl[8]  = '{3,   10'd1, 9'd1, 1'b1, 1'b0, 1'b0, 12'hF0A, 1'b1, 1'b1};
    tbl[9]  = '{225, 10'd0, 9'd0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0};
    tbl[10] = '{132, 10'd0, 9'd0, 1'b1, 1'b0, 1'b1, 12'h000, 1'b1, 1'b1};
    tbl[11] = '{1,   10'd0, 9'd0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1};

    step(1'b1, 12'hF0A);
    step(1'b1, 12'hF0A);

    // Constant colour from reset through one full frame.
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < tbl[i].adv; k++) step(1'b0, 12'hF0A);
      chk($sformatf("vec%0d", i), dut_vec(),
          {tbl[i].x, tbl[i].y, tbl[i].act, tbl[i].pe, tbl[i].fs,
           tbl[i].rgb, tbl[i].hs, tbl[i].vs});
    end

    // Advance into the second frame until both syncs are asserted, then reset for one clock.
    while (m_n < 708) step(1'b0, 12'hF0A);
    chk("hs_vs_low_mid_frame", {34'd0, vga.hs, vga.vs}, 36'd0);
    step(1'b1, 12'hF0A);
    chk("mid_frame_reset", dut_vec(),
        {10'd0, 9'd0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1});

    // Restarted scan must show full-width syncs and frame pulses at the nominal times.
    hs_fall1 = -1; hs_rise1 = -1; hs_fall2 = -1;
    vs_fall  = -1; vs_rise  = -1; fs1 = -1; fs2 = -1;
    prev_hs  = vga.hs;
    prev_vs  = vga.vs;
    for (int k = 0; k < 820; k++) begin
      step(1'b0, 12'($urandom));
      chk("restart_model", dut_vec(), model_vec());
      if (prev_hs && !vga.hs) begin
        if (hs_fall1 < 0) hs_fall1 = m_n;
        else if (hs_fall2 < 0) hs_fall2 = m_n;
      end
      if (!prev_hs && vga.hs && hs_rise1 < 0) hs_rise1 = m_n;
      if (prev_vs && !vga.vs && vs_fall < 0) vs_fall = m_n;
      if (!prev_vs && vga.vs && vs_rise < 0) vs_rise = m_n;
      if (vga.frame_start) begin
        if (fs1 < 0) fs1 = m_n;
        else if (fs2 < 0) fs2 = m_n;
      end
      prev_hs = vga.hs;
      prev_vs = vga.vs;
    end
    chk("hs_first_fall", 36'(hs_fall1), 36'd33);
    chk("hs_width",      36'(hs_rise1 - hs_fall1), 36'(HS * D));
    chk("line_period",   36'(hs_fall2 - hs_fall1), 36'(HT * D));
    chk("vs_first_fall", 36'(vs_fall), 36'd273);
    chk("vs_width",      36'(vs_rise - vs_fall), 36'(VS * HT * D));
    chk("frame_start1",  36'(fs1), 36'(FRAME));
    chk("frame_period",  36'(fs2 - fs1), 36'(FRAME));

    // Random colour with occasional resets, checked every clock.
    for (int k = 0; k < 4000; k++) begin
      step(($urandom_range(0, 499) == 0), 12'($urandom));
      chk("random_model", dut_vec(), model_vec());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_scan_timing.md
Name: vga_scan_timing

Overview:
- Raster scan generator and pixel output stage for the 640x480@60 display path.
- Produces the x/y pixel coordinates that drive the screen compositors (welcome background, game scene).
- Samples the 12-bit colour they return and drives the registered RGB and sync pins to the VGA connector.
- Derives its pixel rate from the system clock with an internal clock enable; there is no second clock domain.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); must be >= 2.
- H_VIS, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_VIS, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync width in lines.
- V_BP, 33, vertical back porch in lines.
- SYNC_POL, 0, asserted level of hs and vs (0 = active-low).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- color  in  12  {R[3:0],G[3:0],B[3:0]} from the compositor for the current x,y.
- x  out  10  current pixel column; 0..H_VIS-1 while visible, 0 in blanking.
- y  out  9  current pixel row; 0..V_VIS-1 while visible, 0 in blanking.
- active  out  1  current h_cnt/v_cnt lies in the visible area.
- pix_en  out  1  one-clk pulse marking the last clk of each pixel period.
- frame_start  out  1  one-clk pulse when counters wrap to (0,0).
- r  out  4  registered red.
- g  out  4  registered green.
- b  out  4  registered blue.
- hs  out  1  registered horizontal sync.
- vs  out  1  registered vertical sync.

Behaviour:
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps; pix_en = (div_cnt == CLK_DIV-1).
- Counters: H_TOT = H_VIS+H_FP+H_SYNC+H_BP (800); V_TOT likewise (525).
  - h_cnt advances only on pix_en.
  - h_cnt == H_TOT-1 -> h_cnt = 0 and v_cnt increments.
  - v_cnt == V_TOT-1 at line end -> v_cnt = 0.
- x, y, active: combinational decode of the registered counters, stable for the full CLK_DIV clks of a pixel. The compositor gets CLK_DIV-1 clks of settling time, which covers its 1-clk ROM latency.
- Sync decode:
  - hs_raw asserted for H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC (656..751).
  - vs_raw asserted for V_VIS+V_FP <= v_cnt < V_VIS+V_FP+V_SYNC (490..491).
  - Asserted level is SYNC_POL.
- Output stage, updated only on pix_en, in the same clk that counters advance:
  - {r,g,b} <= active ? color : 12'h000;
  - hs <= hs_raw; vs <= vs_raw (both decoded from the pre-advance counters).
  - Pins therefore show pixel P during period P+1; rgb, hs and vs are mutually aligned with one pixel of latency.
  - Outputs hold between pix_en pulses.
- Blanking: rgb is forced to 0 whenever active is low, regardless of color.
- frame_start: asserted in the clk following the pix_en on which h_cnt and v_cnt both wrap to 0, for exactly one clk.
- Reset (rst high at a clk edge), takes priority over pix_en:
  - div_cnt=0, h_cnt=0, v_cnt=0, frame_start=0, r=g=b=0.
  - hs=vs=~SYNC_POL (deasserted).
  - After reset, x=0, y=0, active=1.
  - First pix_en occurs CLK_DIV clks after rst deasserts.
- Reset mid-frame: the next scan restarts at (0,0) with no partial sync pulse carried over.
- Frame period = H_TOT*V_TOT*CLK_DIV clks (1,680,000 at defaults).

Test Plan:
- Release rst; count clks -> pix_en first high 4 clks after release, then every 4 clks. x increments 0,1,2 per pixel; y=0; r=g=b=0 and hs=vs=1 until the first pix_en.
- Hold color=12'hF0A; watch line 0 -> {r,g,b}=F,0,A for pixels 0..639 (one pixel late); 0 during blanking; x=0 while h_cnt>=640.
- Measure hs -> low for exactly 96 pixels (384 clks), starting at the pixel following h_cnt=656 on the pins; line period 3200 clks.
- Measure vs -> low for 2 lines (6400 clks); frame_start pulses once per 1,680,000 clks; y wraps 479 -> 0 (blank) -> 0 at the next frame.
- Drive color=x[3:0] replicated in each nibble -> the pin value at pixel period P+1 equals the low nibble of P; no colour leaks past x=639 or y=479.
- Assert rst for 1 clk at h_cnt=300, v_cnt=200 -> next clk x=0, y=0, rgb=0, hs=vs=1; the scan restarts cleanly with full hs/vs timing.
